// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = 16;

  // Two-state controller: clear the register file, then arbitrate writebacks.
  typedef logic [0:0] state_t;
  localparam state_t INIT = 1'b0;
  localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two request sources, the register-file write port and status.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = regfile_pkg::CNT_W
);

  logic              s0_valid;
  logic [ADDR_W-1:0] s0_sel;
  logic [DATA_W-1:0] s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_sel;
  logic [DATA_W-1:0] s1_data;
  logic              s1_ready;
  logic              wEn;
  logic [ADDR_W-1:0] write_sel;
  logic [DATA_W-1:0] write_data;
  logic              init_done;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output s0_valid, s0_sel, s0_data, s1_valid, s1_sel, s1_data,
    input  s0_ready, s1_ready, wEn, write_sel, write_data, init_done, stall_cnt
  );

  modport slave (
    input  s0_valid, s0_sel, s0_data, s1_valid, s1_sel, s1_data,
    output s0_ready, s1_ready, wEn, write_sel, write_data, init_done, stall_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the loser of a contended cycle is favoured next time.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       o_prio
);

  logic r_prio;

  assign gnt[0] = req[0] & (~req[1] | ~r_prio);
  assign gnt[1] = req[1] & (~req[0] |  r_prio);
  assign o_prio = r_prio;

  // Priority only moves when both sources contend; it then points at the loser.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (&req) begin
      r_prio <= ~r_prio;
    end else begin
      r_prio <= r_prio;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Clears registers 1..2**ADDR_W-1 after reset, then arbitrates ALU and load-unit
// writebacks onto a single registered register-file write port.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = regfile_pkg::CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  import regfile_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_wen;
  logic [ADDR_W-1:0] r_wsel;
  logic [DATA_W-1:0] r_wdata;
  logic              r_init_done;
  logic [CNT_W-1:0]  r_stall;

  logic              w_run;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_prio;
  logic              w_stall_evt;

  assign w_run = (r_state == RUN);
  // Gating requests with RUN keeps the arbiter's priority frozen during the clear.
  assign w_req = {bus.s1_valid, bus.s0_valid} & {2{w_run}};

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (w_req),
    .gnt    (w_gnt),
    .o_prio (w_prio)
  );

  assign bus.s0_ready = w_run & (~bus.s1_valid | ~w_prio);
  assign bus.s1_ready = w_run & (~bus.s0_valid |  w_prio);
  assign w_stall_evt  = w_run & ((bus.s0_valid & ~bus.s0_ready) |
                                 (bus.s1_valid & ~bus.s1_ready));

  assign bus.wEn        = r_wen;
  assign bus.write_sel  = r_wsel;
  assign bus.write_data = r_wdata;
  assign bus.init_done  = r_init_done;
  assign bus.stall_cnt  = r_stall;

  // Clear sequence, then one registered write per accepted request; the clear
  // counter wraps to zero after the last register, which marks the end of INIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= INIT;
      r_cnt       <= {{(ADDR_W-1){1'b0}}, 1'b1};
      r_wen       <= 1'b0;
      r_wsel      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_init_done <= 1'b0;
      r_stall     <= {CNT_W{1'b0}};
    end else if (!w_run) begin
      if (r_cnt == {ADDR_W{1'b0}}) begin
        r_wen       <= 1'b0;
        r_init_done <= 1'b1;
        r_state     <= RUN;
      end else begin
        r_wen   <= 1'b1;
        r_wsel  <= r_cnt;
        r_wdata <= {DATA_W{1'b0}};
        r_cnt   <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      // Writes to register 0 are accepted but dropped.
      if (w_gnt[0] && (bus.s0_sel != {ADDR_W{1'b0}})) begin
        r_wen   <= 1'b1;
        r_wsel  <= bus.s0_sel;
        r_wdata <= bus.s0_data;
      end else if (w_gnt[1] && (bus.s1_sel != {ADDR_W{1'b0}})) begin
        r_wen   <= 1'b1;
        r_wsel  <= bus.s1_sel;
        r_wdata <= bus.s1_data;
      end else begin
        r_wen <= 1'b0;
      end
      if (w_stall_evt && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall <= r_stall;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter; two instances (16- and
// 4-bit stall counters) share stimulus and are checked against a reference model.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        rst;
  logic        v0, v1;
  logic [4:0]  sel0, sel1;
  logic [31:0] d0, d1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run;
  int          m_next;
  bit          m_prio;
  bit          m_wen;
  int          m_wsel;
  logic [31:0] m_wdata;
  bit          m_done;
  int          m_stall;
  int          m_gnt;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_a ();
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_b ();

  assign bus_a.s0_valid = v0;   assign bus_b.s0_valid = v0;
  assign bus_a.s0_sel   = sel0; assign bus_b.s0_sel   = sel0;
  assign bus_a.s0_data  = d0;   assign bus_b.s0_data  = d0;
  assign bus_a.s1_valid = v1;   assign bus_b.s1_valid = v1;
  assign bus_a.s1_sel   = sel1; assign bus_b.s1_sel   = sel1;
  assign bus_a.s1_data  = d1;   assign bus_b.s1_data  = d1;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut_a (
    .clock (clock), .reset (rst), .bus (bus_a.slave));
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut_b (
    .clock (clock), .reset (rst), .bus (bus_b.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Spec-level behaviour of one clock edge, using the inputs present before it.
  task automatic model_edge();
    m_gnt = -1;
    if (rst) begin
      m_run = 0; m_next = 1; m_prio = 0; m_wen = 0; m_wsel = 0;
      m_wdata = 32'h0; m_done = 0; m_stall = 0;
    end else if (!m_run) begin
      if (m_next <= 31) begin
        m_wen = 1; m_wsel = m_next; m_wdata = 32'h0; m_next++;
      end else begin
        m_wen = 0; m_done = 1; m_run = 1;
      end
    end else begin
      if (v0 && v1) begin
        m_gnt  = m_prio ? 1 : 0;
        m_prio = (m_gnt == 0);
        m_stall++;
      end else if (v0) begin
        m_gnt = 0;
      end else if (v1) begin
        m_gnt = 1;
      end
      m_wen = 0;
      if (m_gnt == 0 && sel0 != 5'd0) begin
        m_wen = 1; m_wsel = int'(sel0); m_wdata = d0;
      end else if (m_gnt == 1 && sel1 != 5'd0) begin
        m_wen = 1; m_wsel = int'(sel1); m_wdata = d1;
      end
    end
  endtask

  task automatic cycle();
    bit exp_r0, exp_r1;
    @(negedge clock);
    exp_r0 = m_run && (!v1 || !m_prio);
    exp_r1 = m_run && (!v0 ||  m_prio);
    chk("s0_ready", 64'(bus_a.s0_ready), 64'(exp_r0));
    chk("s1_ready", 64'(bus_a.s1_ready), 64'(exp_r1));
    @(posedge clock);
    model_edge();
    #1;
    chk("wEn",        64'(bus_a.wEn),        64'(m_wen));
    chk("write_sel",  64'(bus_a.write_sel),  64'(m_wsel));
    chk("write_data", 64'(bus_a.write_data), 64'(m_wdata));
    chk("init_done",  64'(bus_a.init_done),  64'(m_done));
    chk("stall16",    64'(bus_a.stall_cnt),  64'((m_stall > 65535) ? 65535 : m_stall));
    chk("stall4",     64'(bus_b.stall_cnt),  64'((m_stall > 15) ? 15 : m_stall));
    chk("b_wEn",      64'(bus_b.wEn),        64'(m_wen));
  endtask

  // Refresh only the data of whichever source was just accepted.
  task automatic refresh_accepted();
    if (m_gnt == 0) d0 = $urandom;
    if (m_gnt == 1) d1 = $urandom;
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; sel0 = 5'd0; sel1 = 5'd0; d0 = 32'h0; d1 = 32'h0;
    m_gnt = -1;
    repeat (3) cycle();
    chk("reset_wEn",  64'(bus_a.wEn),       64'd0);
    chk("reset_sel",  64'(bus_a.write_sel), 64'd0);
    chk("reset_done", 64'(bus_a.init_done), 64'd0);

    // Clear sequence with no requests
    rst = 1'b0;
    repeat (31) cycle();
    chk("init_last_sel",  64'(bus_a.write_sel), 64'd31);
    chk("init_not_done",  64'(bus_a.init_done), 64'd0);
    cycle();
    chk("init_done_32",   64'(bus_a.init_done), 64'd1);
    chk("init_wen_off",   64'(bus_a.wEn),       64'd0);

    // Single ALU write
    v0 = 1'b1; sel0 = 5'd5; d0 = 32'hDEADBEEF;
    cycle();
    chk("s0_only_sel",  64'(bus_a.write_sel),  64'd5);
    chk("s0_only_data", 64'(bus_a.write_data), 64'hDEADBEEF);
    chk("s0_only_stall", 64'(bus_a.stall_cnt), 64'd0);
    v0 = 1'b0;
    cycle();

    // Four contended cycles alternate s0, s1, s0, s1
    v0 = 1'b1; sel0 = 5'd1; d0 = $urandom;
    v1 = 1'b1; sel1 = 5'd2; d1 = $urandom;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_order", 64'(bus_a.write_sel), (k % 2 == 0) ? 64'd1 : 64'd2);
      refresh_accepted();
    end
    chk("rr_stall4", 64'(bus_a.stall_cnt), 64'd4);

    // Load-unit write to register 0 is accepted and dropped
    v0 = 1'b0; v1 = 1'b1; sel1 = 5'd0; d1 = 32'h1234;
    cycle();
    chk("sel0_wen",  64'(bus_a.wEn),       64'd0);
    chk("sel0_hold", 64'(bus_a.write_sel), 64'd2);

    // Twenty contended cycles saturate the 4-bit counter
    v0 = 1'b1; sel0 = 5'd7; v1 = 1'b1; sel1 = 5'd9;
    for (int k = 0; k < 20; k++) begin
      cycle();
      refresh_accepted();
    end
    chk("sat_stall16", 64'(bus_a.stall_cnt), 64'd24);
    chk("sat_stall4",  64'(bus_b.stall_cnt), 64'd15);

    // Random traffic; a source holds its request until accepted
    for (int k = 0; k < 80; k++) begin
      if (!(v0 && m_gnt != 0)) begin
        v0 = 1'($urandom_range(0, 1)); sel0 = 5'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (!(v1 && m_gnt != 1)) begin
        v1 = 1'($urandom_range(0, 1)); sel1 = 5'($urandom_range(0, 31)); d1 = $urandom;
      end
      cycle();
    end

    // Reset during RUN with a request in flight, then again mid-clear
    v0 = 1'b1; sel0 = 5'd3; d0 = 32'hCAFE0003; v1 = 1'b0;
    rst = 1'b1;
    cycle();
    chk("run_reset_wen",   64'(bus_a.wEn),       64'd0);
    chk("run_reset_stall", 64'(bus_a.stall_cnt), 64'd0);
    rst = 1'b0;
    repeat (10) cycle();
    chk("mid_init_sel", 64'(bus_a.write_sel), 64'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("restart_sel", 64'(bus_a.write_sel), 64'd1);
    repeat (31) cycle();
    chk("restart_done",  64'(bus_a.init_done), 64'd1);
    chk("restart_stall", 64'(bus_a.stall_cnt), 64'd0);
    repeat (3) cycle();
    chk("post_init_sel", 64'(bus_a.write_sel), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
